// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// Circular store buffer sitting between dispatch, the LSU execute stage, ROB
// commit and the D-cache write port.
//   * Dispatch allocates consecutive SB IDs to up to DISPATCH_WIDTH stores.
//   * Execute fills in address / data / byte enables for an allocated entry.
//   * ROB commit marks entries committed, strictly in allocation order.
//   * Committed, executed entries drain in order to memory.
//   * Flush throws away every uncommitted entry. Committed stores are kept and
//     always reach memory.
//
// Optional feature (macro SB_STORE_FWD_EN): store-to-load forwarding. A load
// presents its address, byte enables and the tail snapshot taken at its
// dispatch. The buffer searches all older stores and either forwards data or
// asks the load to stall.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_i              pipeline flush (kills uncommitted entries)
//   alloc_valid_i        per-lane store allocation request
//   alloc_ready_o        every lane may allocate this cycle
//   alloc_sb_id_o        ID granted to each lane
//   exec_*               execute write of addr/data/be into an entry
//   commit_*             ROB commit lanes (valid, is_store, sb_id)
//   mem_req_*            drain request to the D-cache
//   sb_empty_o           no entries held
//   sb_count_o           number of occupied entries
//   sb_tail_o            current tail pointer
//   ld_query_*           (SB_STORE_FWD_EN) load forwarding query
//   fwd_hit_o            (SB_STORE_FWD_EN) forward data is valid
//   fwd_data_o           (SB_STORE_FWD_EN) forwarded data
//   fwd_stall_o          (SB_STORE_FWD_EN) load must wait
//
// Handshake: the drain port uses valid/ready. A transfer happens on a rising
// edge where mem_req_valid_o && mem_req_ready_i. While valid is high and ready
// is low, valid and the request fields hold steady. Valid never depends on
// ready.
// -----------------------------------------------------------------------------

package config_pkg;
  typedef struct packed {
    int unsigned XLEN;
    int unsigned PLEN;
    int unsigned INSTR_PER_FETCH;
    int unsigned NRET;
  } cfg_t;

  localparam cfg_t EmptyCfg = '{XLEN: 32, PLEN: 32, INSTR_PER_FETCH: 4, NRET: 2};
endpackage

module store_buffer #(
  parameter config_pkg::cfg_t Cfg            = config_pkg::EmptyCfg,
  parameter int unsigned      SB_DEPTH       = 16,
  parameter int unsigned      SB_IDX_WIDTH   = $clog2(SB_DEPTH),
  parameter int unsigned      DISPATCH_WIDTH = Cfg.INSTR_PER_FETCH,
  parameter int unsigned      COMMIT_WIDTH   = Cfg.NRET,
  parameter int unsigned      BE_W           = Cfg.XLEN / 8
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic                                         flush_i,

  input  logic [DISPATCH_WIDTH-1:0]                    alloc_valid_i,
  output logic                                         alloc_ready_o,
  output logic [DISPATCH_WIDTH-1:0][SB_IDX_WIDTH-1:0]  alloc_sb_id_o,

  input  logic                                         exec_valid_i,
  input  logic [SB_IDX_WIDTH-1:0]                      exec_sb_id_i,
  input  logic [Cfg.PLEN-1:0]                          exec_addr_i,
  input  logic [Cfg.XLEN-1:0]                          exec_data_i,
  input  logic [BE_W-1:0]                              exec_be_i,

  input  logic [COMMIT_WIDTH-1:0]                      commit_valid_i,
  input  logic [COMMIT_WIDTH-1:0]                      commit_is_store_i,
  input  logic [COMMIT_WIDTH-1:0][SB_IDX_WIDTH-1:0]    commit_sb_id_i,

  output logic                                         mem_req_valid_o,
  input  logic                                         mem_req_ready_i,
  output logic [Cfg.PLEN-1:0]                          mem_req_addr_o,
  output logic [Cfg.XLEN-1:0]                          mem_req_data_o,
  output logic [BE_W-1:0]                              mem_req_be_o,

`ifdef SB_STORE_FWD_EN
  input  logic                                         ld_query_valid_i,
  input  logic [Cfg.PLEN-1:0]                          ld_query_addr_i,
  input  logic [BE_W-1:0]                              ld_query_be_i,
  input  logic [SB_IDX_WIDTH-1:0]                      ld_query_tail_i,
  output logic                                         fwd_hit_o,
  output logic [Cfg.XLEN-1:0]                          fwd_data_o,
  output logic                                         fwd_stall_o,
`endif

  output logic                                         sb_empty_o,
  output logic [$clog2(SB_DEPTH+1)-1:0]                sb_count_o,
  output logic [SB_IDX_WIDTH-1:0]                      sb_tail_o
);

  localparam int unsigned XLEN  = Cfg.XLEN;
  localparam int unsigned PLEN  = Cfg.PLEN;
  localparam int unsigned CNT_W = $clog2(SB_DEPTH + 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [SB_IDX_WIDTH-1:0] r_head;
  logic [SB_IDX_WIDTH-1:0] r_commit_ptr;
  logic [SB_IDX_WIDTH-1:0] r_tail;
  logic [CNT_W-1:0]        r_count;
  logic [CNT_W-1:0]        r_committed;
  logic [SB_DEPTH-1:0]     r_executed;
  logic [PLEN-1:0]         r_addr [SB_DEPTH];
  logic [XLEN-1:0]         r_data [SB_DEPTH];
  logic [BE_W-1:0]         r_be   [SB_DEPTH];

  // ---------------------------------------------------------------------------
  // Allocation
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]        w_free;
  logic                    w_alloc_ready;
  logic                    w_do_alloc;
  logic [CNT_W-1:0]        w_alloc_pop;
  logic [CNT_W-1:0]        w_alloc_n;
  logic [SB_IDX_WIDTH-1:0] w_run;
  logic [SB_IDX_WIDTH-1:0] w_off;
  logic [SB_DEPTH-1:0]     w_alloc_mask;

  // Readiness looks at registered occupancy only, so it never depends on
  // this cycle's pops or commits.
  assign w_free        = CNT_W'(SB_DEPTH) - r_count;
  assign w_alloc_ready = (w_free >= CNT_W'(DISPATCH_WIDTH));
  assign w_do_alloc    = w_alloc_ready && !flush_i;
  assign w_alloc_n     = w_do_alloc ? w_alloc_pop : '0;

  // Each lane's ID is the tail plus the number of requesting lanes below it.
  // IDs are produced for every lane, including lanes that are not valid.
  always_comb begin
    w_run       = '0;
    w_alloc_pop = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      alloc_sb_id_o[i] = r_tail + w_run;
      w_run            = w_run + SB_IDX_WIDTH'(alloc_valid_i[i]);
      w_alloc_pop      = w_alloc_pop + CNT_W'(alloc_valid_i[i]);
    end
  end

  // An entry is being granted when its distance from the tail is below the
  // number of lanes allocated this cycle.
  always_comb begin
    w_off        = '0;
    w_alloc_mask = '0;
    for (int e = 0; e < SB_DEPTH; e++) begin
      w_off           = SB_IDX_WIDTH'(e) - r_tail;
      w_alloc_mask[e] = (CNT_W'(w_off) < w_alloc_n);
    end
  end

  // ---------------------------------------------------------------------------
  // Commit
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] w_ncommit;
  logic             w_commit_err;

  // The k-th committing store lane must name commit_ptr + k. Non-store lanes
  // are skipped and do not consume an ID.
  always_comb begin
    w_ncommit    = '0;
    w_commit_err = 1'b0;
    for (int c = 0; c < COMMIT_WIDTH; c++) begin
      if (commit_valid_i[c] && commit_is_store_i[c]) begin
        if (commit_sb_id_i[c] != r_commit_ptr + SB_IDX_WIDTH'(w_ncommit)) begin
          w_commit_err = 1'b1;
        end
        w_ncommit = w_ncommit + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drain
  // ---------------------------------------------------------------------------
  logic w_mem_valid;
  logic w_pop;

  assign w_mem_valid = (r_committed != '0) && r_executed[r_head];
  assign w_pop       = w_mem_valid && mem_req_ready_i;

  // Request fields are zeroed when there is nothing to send. This keeps the
  // port quiet out of reset without resetting the payload arrays.
  assign mem_req_valid_o = w_mem_valid;
  assign mem_req_addr_o  = w_mem_valid ? r_addr[r_head] : '0;
  assign mem_req_data_o  = w_mem_valid ? r_data[r_head] : '0;
  assign mem_req_be_o    = w_mem_valid ? r_be[r_head]   : '0;

  // ---------------------------------------------------------------------------
  // Next-state
  // ---------------------------------------------------------------------------
  logic [SB_IDX_WIDTH-1:0] w_cp_next;
  logic [CNT_W-1:0]        w_committed_next;
  logic [CNT_W-1:0]        w_count_next;
  logic [SB_IDX_WIDTH-1:0] w_tail_next;
  logic [SB_IDX_WIDTH-1:0] w_head_next;

  assign w_cp_next        = r_commit_ptr + SB_IDX_WIDTH'(w_ncommit);
  assign w_committed_next = r_committed + w_ncommit - CNT_W'(w_pop);
  assign w_head_next      = r_head + SB_IDX_WIDTH'(w_pop);

  // Commits in the flush cycle land first. The buffer then shrinks back to
  // exactly the committed entries, which sit between head and the new commit
  // pointer.
  assign w_tail_next  = flush_i ? w_cp_next
                                : r_tail + SB_IDX_WIDTH'(w_alloc_n);
  assign w_count_next = flush_i ? w_committed_next
                                : r_count + w_alloc_n - CNT_W'(w_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head       <= '0;
      r_commit_ptr <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_committed  <= '0;
    end else begin
      r_head       <= w_head_next;
      r_commit_ptr <= w_cp_next;
      r_tail       <= w_tail_next;
      r_count      <= w_count_next;
      r_committed  <= w_committed_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry storage
  // ---------------------------------------------------------------------------
  logic w_exec_we;
  assign w_exec_we = exec_valid_i && !flush_i;

  // Granting an entry clears its executed bit. A legal execute never targets
  // an entry granted in the same cycle, so the set below cannot collide with
  // the clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_executed <= '0;
    end else begin
      for (int e = 0; e < SB_DEPTH; e++) begin
        if (w_alloc_mask[e]) begin
          r_executed[e] <= 1'b0;
        end
      end
      if (w_exec_we) begin
        r_executed[exec_sb_id_i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_exec_we) begin
      r_addr[exec_sb_id_i] <= exec_addr_i;
      r_data[exec_sb_id_i] <= exec_data_i;
      r_be[exec_sb_id_i]   <= exec_be_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Status
  // ---------------------------------------------------------------------------
  assign alloc_ready_o = w_alloc_ready;
  assign sb_empty_o    = (r_count == '0);
  assign sb_count_o    = r_count;
  assign sb_tail_o     = r_tail;

  // ---------------------------------------------------------------------------
  // Protocol checks
  // ---------------------------------------------------------------------------
  logic [SB_IDX_WIDTH-1:0] w_exec_off;
  logic                    w_exec_in_range;

  assign w_exec_off      = exec_sb_id_i - r_head;
  assign w_exec_in_range = (CNT_W'(w_exec_off) < r_count);

  a_exec_in_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_exec_we |-> w_exec_in_range);

  a_commit_in_order : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !w_commit_err);

`ifdef SB_STORE_FWD_EN
  // ---------------------------------------------------------------------------
  // Store-to-load forwarding
  // ---------------------------------------------------------------------------
  localparam int unsigned OFF_W = $clog2(BE_W);

  logic [SB_IDX_WIDTH-1:0] w_fwd_dist;
  logic [CNT_W-1:0]        w_fwd_len;
  logic [SB_IDX_WIDTH-1:0] w_fwd_idx;
  logic                    w_fwd_unexec;
  logic                    w_fwd_found;
  logic                    w_fwd_cover;
  logic [XLEN-1:0]         w_fwd_data;

  // The older stores run from head up to the load's tail snapshot. If head has
  // already passed the snapshot, all of those stores have drained. That case
  // shows up as a distance larger than the occupancy, and the range is then
  // treated as empty. Because the scan goes oldest to youngest, the last
  // overlapping match found is the youngest one.
  always_comb begin
    w_fwd_dist   = ld_query_tail_i - r_head;
    w_fwd_len    = CNT_W'(w_fwd_dist);
    if (w_fwd_len > r_count) begin
      w_fwd_len = '0;
    end
    w_fwd_idx    = '0;
    w_fwd_unexec = 1'b0;
    w_fwd_found  = 1'b0;
    w_fwd_cover  = 1'b0;
    w_fwd_data   = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      w_fwd_idx = r_head + SB_IDX_WIDTH'(i);
      if (CNT_W'(i) < w_fwd_len) begin
        if (!r_executed[w_fwd_idx]) begin
          w_fwd_unexec = 1'b1;
        end else if ((r_addr[w_fwd_idx][PLEN-1:OFF_W] == ld_query_addr_i[PLEN-1:OFF_W]) &&
                     ((r_be[w_fwd_idx] & ld_query_be_i) != '0)) begin
          w_fwd_found = 1'b1;
          w_fwd_cover = ((r_be[w_fwd_idx] & ld_query_be_i) == ld_query_be_i);
          w_fwd_data  = r_data[w_fwd_idx];
        end
      end
    end

    fwd_hit_o   = 1'b0;
    fwd_data_o  = '0;
    fwd_stall_o = 1'b0;
    if (ld_query_valid_i) begin
      if (w_fwd_unexec || (w_fwd_found && !w_fwd_cover)) begin
        fwd_stall_o = 1'b1;
      end else if (w_fwd_found) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = w_fwd_data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        flush;
  logic [3:0]  alloc_valid;
  logic        alloc_ready;
  logic [15:0] alloc_ids;
  logic        exec_valid;
  logic [3:0]  exec_id;
  logic [31:0] exec_addr;
  logic [31:0] exec_data;
  logic [3:0]  exec_be;
  logic [1:0]  commit_valid;
  logic [1:0]  commit_is_store;
  logic [7:0]  commit_ids;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_be;
  logic        sb_empty;
  logic [4:0]  sb_count;
  logic [3:0]  sb_tail;
`ifdef SB_STORE_FWD_EN
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [3:0]  ld_be;
  logic [3:0]  ld_tail;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        fwd_stall;
`endif

  store_buffer dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .flush_i           (flush),
    .alloc_valid_i     (alloc_valid),
    .alloc_ready_o     (alloc_ready),
    .alloc_sb_id_o     (alloc_ids),
    .exec_valid_i      (exec_valid),
    .exec_sb_id_i      (exec_id),
    .exec_addr_i       (exec_addr),
    .exec_data_i       (exec_data),
    .exec_be_i         (exec_be),
    .commit_valid_i    (commit_valid),
    .commit_is_store_i (commit_is_store),
    .commit_sb_id_i    (commit_ids),
    .mem_req_valid_o   (mem_valid),
    .mem_req_ready_i   (mem_ready),
    .mem_req_addr_o    (mem_addr),
    .mem_req_data_o    (mem_data),
    .mem_req_be_o      (mem_be),
`ifdef SB_STORE_FWD_EN
    .ld_query_valid_i  (ld_valid),
    .ld_query_addr_i   (ld_addr),
    .ld_query_be_i     (ld_be),
    .ld_query_tail_i   (ld_tail),
    .fwd_hit_o         (fwd_hit),
    .fwd_data_o        (fwd_data),
    .fwd_stall_o       (fwd_stall),
`endif
    .sb_empty_o        (sb_empty),
    .sb_count_o        (sb_count),
    .sb_tail_o         (sb_tail)
  );

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Addresses of the stores in the order they must reach memory.
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_valid === 1'b1 && mem_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("drain_unexpected", mem_addr, 32'hFFFF_FFFF);
      end else begin
        chk("drain_order", mem_addr, exp_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3:0]  av;
    logic        ev;
    logic [3:0]  eid;
    logic [31:0] ea;
    logic [31:0] ed;
    logic [3:0]  ebe;
    logic [1:0]  cv;
    logic [1:0]  cs;
    logic [7:0]  cid;
    logic        mr;
    logic        fl;
    logic        x_rdy;
    logic [15:0] x_ids;
    logic [4:0]  x_cnt;
    logic [3:0]  x_tail;
    logic        x_mv;
    logic [31:0] x_ma;
    logic [31:0] x_md;
    logic [3:0]  x_mbe;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] av, input logic ev, input logic [3:0] eid,
                     input logic [31:0] ea, input logic [31:0] ed, input logic [3:0] ebe,
                     input logic [1:0] cv, input logic [1:0] cs, input logic [7:0] cid,
                     input logic mr, input logic fl,
                     input logic x_rdy, input logic [15:0] x_ids, input logic [4:0] x_cnt,
                     input logic [3:0] x_tail, input logic x_mv, input logic [31:0] x_ma,
                     input logic [31:0] x_md, input logic [3:0] x_mbe);
    vec_t v;
    v = '{av, ev, eid, ea, ed, ebe, cv, cs, cid, mr, fl,
          x_rdy, x_ids, x_cnt, x_tail, x_mv, x_ma, x_md, x_mbe};
    tbl.push_back(v);
  endtask

  task automatic drive_idle();
    alloc_valid     = '0;
    exec_valid      = 1'b0;
    exec_id         = '0;
    exec_addr       = '0;
    exec_data       = '0;
    exec_be         = '0;
    commit_valid    = '0;
    commit_is_store = '0;
    commit_ids      = '0;
    mem_ready       = 1'b0;
    flush           = 1'b0;
`ifdef SB_STORE_FWD_EN
    ld_valid = 1'b0;
    ld_addr  = '0;
    ld_be    = '0;
    ld_tail  = '0;
`endif
  endtask

  // Expectations describe the cycle in which the row is driven, before its
  // rising edge takes effect.
  initial begin
    //   av   ev eid  addr          data          be    cv     cs     cid    mr fl | rdy ids      cnt tail mv addr          data          be
    // reset state, then allocate lanes 0,1,3
    add(4'h0,0,4'h0,32'h0,        32'h0,        4'h0,2'b00,2'b00,8'h00,0,0, 1,16'h0000,0, 4'h0,0,32'h0,        32'h0,        4'h0);
    add(4'hB,0,4'h0,32'h0,        32'h0,        4'h0,2'b00,2'b00,8'h00,0,0, 1,16'h2210,0, 4'h0,0,32'h0,        32'h0,        4'h0);
    // execute, commit, back-pressure for three cycles, then drain
    add(4'h0,1,4'h0,32'h8000_0010,32'hDEAD_BEEF,4'hF,2'b00,2'b00,8'h00,0,0, 1,16'h3333,3, 4'h3,0,32'h0,        32'h0,        4'h0);
    add(4'h0,0,4'h0,32'h0,        32'h0,        4'h0,2'b01,2'b01,8'h00,0,0, 1,16'h3333,3, 4'h3,0,32'h0,        32'h0,        4'h0);
    add(4'h0,0,4'h0,32'h0,        32'h0,        4'h0,2'b00,2'b00,8'h00,0,0, 1,16'h3333,3, 4'h3,1,32'h8000_0010,32'hDEAD_BEEF,4'hF);
    add(4'h0,0,4'h0,32'h0,        32'h0,        4'h0,2'b00,2'b00,8'h00,0,0, 1,16'h3333,3, 4'h3,1,32'h8000_0010,32'hDEAD_BEEF,4'hF);
    add(4'h0,0,4'h0,32'h0,        32'h0,        4'h0,2'b00,2'b00,8'h00,0,0, 1,16'h3333,3, 4'h3,1,32'h8000_0010,32'hDEAD_BEEF,4'hF);
    add(4'h0,0,4'h0,32'h0,        32'h0,        4'h0,2'b00,2'b00,8'h00,1,0, 1,16'h3333,3, 4'h3,1,32'h8000_0010,32'hDEAD_BEEF,4'hF);
    // finish IDs 1 and 2 (dual commit) and drain them
    add(4'h0,1,4'h1,32'h0000_0100,32'h0000_0011,4'hF,2'b00,2'b00,8'h00,0,0, 1,16'h3333,2, 4'h3,0,32'h0,        32'h0,        4'h0);
    add(4'h0,1,4'h2,32'h0000_0104,32'h0000_0022,4'h3,2'b11,2'b11,8'h21,0,0, 1,16'h3333,2, 4'h3,0,32'h0,        32'h0,        4'h0);
    add(4'h0,0,4'h0,32'h0,        32'h0,        4'h0,2'b00,2'b00,8'h00,1,0, 1,16'h3333,2, 4'h3,1,32'h0000_0100,32'h0000_0011,4'hF);
    add(4'h0,0,4'h0,32'h0,        32'h0,        4'h0,2'b00,2'b00,8'h00,1,0, 1,16'h3333,1, 4'h3,1,32'h0000_0104,32'h0000_0022,4'h3);
    add(4'h0,0,4'h0,32'h0,        32'h0,        4'h0,2'b00,2'b00,8'h00,0,0, 1,16'h3333,0, 4'h3,0,32'h0,        32'h0,        4'h0);
    // fill up; IDs wrap 15 -> 0; ready drops once free < 4
    add(4'hF,0,4'h0,32'h0,        32'h0,        4'h0,2'b00,2'b00,8'h00,0,0, 1,16'h6543,0, 4'h3,0,32'h0,        32'h0,        4'h0);
    add(4'hF,0,4'h0,32'h0,        32'h0,        4'h0,2'b00,2'b00,8'h00,0,0, 1,16'hA987,4, 4'h7,0,32'h0,        32'h0,        4'h0);
    add(4'hF,0,4'h0,32'h0,        32'h0,        4'h0,2'b00,2'b00,8'h00,0,0, 1,16'hEDCB,8, 4'hB,0,32'h0,        32'h0,        4'h0);
    add(4'h1,0,4'h0,32'h0,        32'h0,        4'h0,2'b00,2'b00,8'h00,0,0, 1,16'h000F,12,4'hF,0,32'h0,        32'h0,        4'h0);
    add(4'hF,0,4'h0,32'h0,        32'h0,        4'h0,2'b00,2'b00,8'h00,0,0, 0,16'h3210,13,4'h0,0,32'h0,        32'h0,        4'h0);
    add(4'h0,1,4'h3,32'h0000_0200,32'h0000_0033,4'hF,2'b01,2'b01,8'h03,0,0, 0,16'h0000,13,4'h0,0,32'h0,        32'h0,        4'h0);
    add(4'h0,0,4'h0,32'h0,        32'h0,        4'h0,2'b00,2'b00,8'h00,1,0, 0,16'h0000,13,4'h0,1,32'h0000_0200,32'h0000_0033,4'hF);
    // back at exactly 4 free: ready again; take 3 -> count 15
    add(4'h7,0,4'h0,32'h0,        32'h0,        4'h0,2'b00,2'b00,8'h00,0,0, 1,16'h3210,12,4'h0,0,32'h0,        32'h0,        4'h0);
    // non-store lane 1 carries a junk ID that must be ignored
    add(4'h0,1,4'h4,32'h0000_0300,32'h0000_0044,4'hF,2'b11,2'b01,8'h94,0,0, 0,16'h3333,15,4'h3,0,32'h0,        32'h0,        4'h0);
    // pop + commit + (refused) alloc at count 15
    add(4'h1,0,4'h0,32'h0,        32'h0,        4'h0,2'b01,2'b01,8'h05,1,0, 0,16'h4443,15,4'h3,1,32'h0000_0300,32'h0000_0044,4'hF);
    add(4'h0,1,4'h5,32'h0000_0400,32'h0000_0055,4'hF,2'b01,2'b01,8'h06,0,0, 0,16'h3333,14,4'h3,0,32'h0,        32'h0,        4'h0);
    add(4'h0,1,4'h6,32'h0000_0404,32'h0000_0066,4'hC,2'b00,2'b00,8'h00,0,0, 0,16'h3333,14,4'h3,1,32'h0000_0400,32'h0000_0055,4'hF);
    // flush with a commit and a pop in the same cycle; execute is ignored
    add(4'h0,1,4'h7,32'h0000_0408,32'h0000_0077,4'hF,2'b01,2'b01,8'h07,1,1, 0,16'h3333,14,4'h3,1,32'h0000_0400,32'h0000_0055,4'hF);
    add(4'h0,0,4'h0,32'h0,        32'h0,        4'h0,2'b00,2'b00,8'h00,0,0, 1,16'h8888,2, 4'h8,1,32'h0000_0404,32'h0000_0066,4'hC);
    add(4'h0,0,4'h0,32'h0,        32'h0,        4'h0,2'b00,2'b00,8'h00,1,0, 1,16'h8888,2, 4'h8,1,32'h0000_0404,32'h0000_0066,4'hC);
    add(4'h0,1,4'h7,32'h0000_0408,32'h0000_0077,4'hF,2'b00,2'b00,8'h00,1,0, 1,16'h8888,1, 4'h8,0,32'h0,        32'h0,        4'h0);
    add(4'h0,0,4'h0,32'h0,        32'h0,        4'h0,2'b00,2'b00,8'h00,1,0, 1,16'h8888,1, 4'h8,1,32'h0000_0408,32'h0000_0077,4'hF);
    // alloc + pop + commit + execute all in one cycle
    add(4'h3,0,4'h0,32'h0,        32'h0,        4'h0,2'b00,2'b00,8'h00,0,0, 1,16'hAA98,0, 4'h8,0,32'h0,        32'h0,        4'h0);
    add(4'h0,1,4'h8,32'h0000_0500,32'h0000_0088,4'hF,2'b01,2'b01,8'h08,0,0, 1,16'hAAAA,2, 4'hA,0,32'h0,        32'h0,        4'h0);
    add(4'hF,1,4'h9,32'h0000_0504,32'h0000_0099,4'hF,2'b01,2'b01,8'h09,1,0, 1,16'hDCBA,2, 4'hA,1,32'h0000_0500,32'h0000_0088,4'hF);
    add(4'h0,0,4'h0,32'h0,        32'h0,        4'h0,2'b00,2'b00,8'h00,1,0, 1,16'hEEEE,5, 4'hE,1,32'h0000_0504,32'h0000_0099,4'hF);
    add(4'h0,0,4'h0,32'h0,        32'h0,        4'h0,2'b00,2'b00,8'h00,0,0, 1,16'hEEEE,4, 4'hE,0,32'h0,        32'h0,        4'h0);
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    exp_q = '{32'h8000_0010, 32'h0000_0100, 32'h0000_0104, 32'h0000_0200,
              32'h0000_0300, 32'h0000_0400, 32'h0000_0404, 32'h0000_0408,
              32'h0000_0500, 32'h0000_0504, 32'h0000_0600};
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    foreach (tbl[r]) begin
      @(posedge clk);
      #1;
      alloc_valid     = tbl[r].av;
      exec_valid      = tbl[r].ev;
      exec_id         = tbl[r].eid;
      exec_addr       = tbl[r].ea;
      exec_data       = tbl[r].ed;
      exec_be         = tbl[r].ebe;
      commit_valid    = tbl[r].cv;
      commit_is_store = tbl[r].cs;
      commit_ids      = tbl[r].cid;
      mem_ready       = tbl[r].mr;
      flush           = tbl[r].fl;
      @(negedge clk);
      chk($sformatf("row%0d_ready", r), 32'(alloc_ready), 32'(tbl[r].x_rdy));
      chk($sformatf("row%0d_ids", r),   32'(alloc_ids),   32'(tbl[r].x_ids));
      chk($sformatf("row%0d_count", r), 32'(sb_count),    32'(tbl[r].x_cnt));
      chk($sformatf("row%0d_empty", r), 32'(sb_empty),    32'(tbl[r].x_cnt == 5'd0));
      chk($sformatf("row%0d_tail", r),  32'(sb_tail),     32'(tbl[r].x_tail));
      chk($sformatf("row%0d_mvalid", r),32'(mem_valid),   32'(tbl[r].x_mv));
      chk($sformatf("row%0d_maddr", r), mem_addr,         tbl[r].x_ma);
      chk($sformatf("row%0d_mdata", r), mem_data,         tbl[r].x_md);
      chk($sformatf("row%0d_mbe", r),   32'(mem_be),      32'(tbl[r].x_mbe));
    end

    // Random-length back-pressure: the request must hold steady throughout.
    // State here: head 10, tail 14, count 4, nothing committed.
    @(posedge clk);
    #1;
    drive_idle();
    exec_valid      = 1'b1;
    exec_id         = 4'hA;
    exec_addr       = 32'h0000_0600;
    exec_data       = 32'hA5A5_0001;
    exec_be         = 4'h3;
    commit_valid    = 2'b01;
    commit_is_store = 2'b01;
    commit_ids      = 8'h0A;
    @(posedge clk);
    #1;
    drive_idle();
    n = $urandom_range(2, 5);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk("hold_valid", 32'(mem_valid), 32'd1);
      chk("hold_addr",  mem_addr,       32'h0000_0600);
      chk("hold_data",  mem_data,       32'hA5A5_0001);
      chk("hold_be",    32'(mem_be),    32'h3);
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("accept_valid", 32'(mem_valid), 32'd1);
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("after_pop_count",  32'(sb_count),  32'd3);
    chk("after_pop_mvalid", 32'(mem_valid), 32'd0);

`ifdef SB_STORE_FWD_EN
    // Full cover forwards; a younger partial store forces a stall.
    @(posedge clk);
    #1;
    exec_valid = 1'b1;
    exec_id    = 4'hB;
    exec_addr  = 32'h0000_0100;
    exec_data  = 32'h1122_3344;
    exec_be    = 4'hF;
    @(posedge clk);
    #1;
    drive_idle();
    ld_valid = 1'b1;
    ld_addr  = 32'h0000_0100;
    ld_be    = 4'h3;
    ld_tail  = 4'hC;
    @(negedge clk);
    chk("fwd_hit",       32'(fwd_hit),   32'd1);
    chk("fwd_data",      fwd_data,       32'h1122_3344);
    chk("fwd_stall_off", 32'(fwd_stall), 32'd0);
    @(posedge clk);
    #1;
    drive_idle();
    exec_valid = 1'b1;
    exec_id    = 4'hC;
    exec_addr  = 32'h0000_0100;
    exec_data  = 32'h0000_00AA;
    exec_be    = 4'h1;
    @(posedge clk);
    #1;
    drive_idle();
    ld_valid = 1'b1;
    ld_addr  = 32'h0000_0100;
    ld_be    = 4'h3;
    ld_tail  = 4'hD;
    @(negedge clk);
    chk("fwd_stall",   32'(fwd_stall), 32'd1);
    chk("fwd_hit_off", 32'(fwd_hit),   32'd0);
    @(posedge clk);
    #1;
    drive_idle();
`endif

    @(negedge clk);
    chk("drain_all_seen", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net in case the sequence stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
